fast_to_slow_clk_signal: RTL and testbench

FAST_TO_SLOW_CLK_SIGNAL -- requirements
Module: fast_to_slow_clk_signal

---
 rtl/clk_xing_pkg.sv | 13 +
 rtl/slow_clk_rise_detect.sv | 19 +
 rtl/fast_to_slow_clk_signal.sv | 75 +++++++
 tb/tb_fast_to_slow_clk_signal.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_xing_pkg.sv
// Shared defaults and sizing helpers for the fast/slow clock-crossing event blocks.
package clk_xing_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/slow_clk_rise_detect.sv
// Detects a rising edge of the slow clock by sampling it as a level on clk_fast.
module slow_clk_rise_detect (
  input  logic clk_fast,
  input  logic reset,
  input  logic clk_slow,
  output logic slow_rise
);

  logic prev_slow;

  // Resets high so a slow clock already high at release is not seen as an edge.
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) prev_slow <= 1'b1;
    else        prev_slow <= clk_slow;
  end

  assign slow_rise = !prev_slow && clk_slow;

endmodule

// File: rtl/fast_to_slow_clk_signal.sv
// Buffers fast-domain event strobes with payload and replays them one per slow-clock period.
module fast_to_slow_clk_signal
  import clk_xing_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk_fast,
  input  logic              reset,
  input  logic              clk_slow,
  input  logic              signal_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              signal_out,
  output logic [DATA_W-1:0] data_out,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic              slow_rise;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  slow_clk_rise_detect u_rise (
    .clk_fast  (clk_fast),
    .reset     (reset),
    .clk_slow  (clk_slow),
    .slow_rise (slow_rise)
  );

  // A pop frees a slot in the same cycle, so a full buffer can still accept on a slow edge.
  always_comb begin
    pop       = slow_rise && (count != '0);
    push      = signal_in && (!full || pop);
    overflow  = signal_in && !push;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_fast) begin
    if (push) mem[tail] <= data_in;
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  // Output only changes on a slow edge; reads the pre-push head so there is no bypass.
  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      signal_out <= 1'b0;
      data_out   <= '0;
    end else if (slow_rise) begin
      signal_out <= pop;
      if (pop) data_out <= mem[head];
    end
  end

endmodule

// File: tb/tb_fast_to_slow_clk_signal.sv
// Randomized and directed check of fast_to_slow_clk_signal against a queue-based event model.
module tb_fast_to_slow_clk_signal;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 4;

  logic          clk_fast = 1'b0;
  logic          reset;
  logic          clk_slow;
  logic          signal_in;
  logic [DW-1:0] data_in;
  logic          full;
  logic          signal_out;
  logic [DW-1:0] data_out;
  logic          overflow;

  fast_to_slow_clk_signal #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk_fast   (clk_fast),
    .reset      (reset),
    .clk_slow   (clk_slow),
    .signal_in  (signal_in),
    .data_in    (data_in),
    .full       (full),
    .signal_out (signal_out),
    .data_out   (data_out),
    .overflow   (overflow)
  );

  always #5 clk_fast = ~clk_fast;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending events in push order plus the currently presented output.
  logic [DW-1:0] q[$];
  logic          m_sig;
  logic [DW-1:0] m_data;
  logic          m_prev;
  logic          slow_lvl;
  int            ph;
  int            hl;
  bit            rand_hl;
  bit            seen5;
  int            a5_cycles;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sig  = 1'b0;
    m_data = '0;
    m_prev = 1'b1;
  endtask

  task automatic cycle(input logic si, input logic [DW-1:0] d);
    bit rise, pop, push;
    int sz;
    clk_slow  = slow_lvl;
    signal_in = si;
    data_in   = d;
    @(negedge clk_fast);
    sz   = q.size();
    rise = slow_lvl && !m_prev;
    pop  = rise && (sz > 0);
    push = si && ((sz < DP) || pop);
    check("signal_out", DW'(signal_out), DW'(m_sig));
    check("data_out",   data_out, m_data);
    check("full",       DW'(full), DW'(sz == DP));
    check("overflow",   DW'(overflow), DW'(si && !push));
    if (signal_out && data_out == 32'h5) seen5 = 1'b1;
    if (signal_out && data_out == 32'hA5) a5_cycles++;
    if (rise) m_sig = pop;
    if (pop)  m_data = q.pop_front();
    if (push) q.push_back(d);
    m_prev = slow_lvl;
    @(posedge clk_fast);
    #1;
    ph++;
    if (ph >= hl) begin
      ph = 0;
      slow_lvl = ~slow_lvl;
      if (rand_hl) hl = $urandom_range(5, 2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  // Spin idle until the next cycle presents a slow rising edge.
  task automatic to_rise();
    int guard = 0;
    while (!(slow_lvl && !m_prev) && guard < 100) begin
      cycle(1'b0, '0);
      guard++;
    end
    check("rise_reached", DW'(guard < 100), DW'(1));
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_fast);
      check("rst_signal_out", DW'(signal_out), '0);
      check("rst_data_out",   data_out, '0);
      check("rst_full",       DW'(full), '0);
      check("rst_overflow",   DW'(overflow), '0);
      @(posedge clk_fast);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b0;
    signal_in = 1'b0;
    data_in   = '0;
    slow_lvl  = 1'b1;
    clk_slow  = 1'b1;
    ph        = 0;
    hl        = 2;
    rand_hl   = 1'b0;
    seen5     = 1'b0;
    a5_cycles = 0;
    model_reset();
    reset_cycles(3);
    reset = 1'b1;

    // Release with clk_slow high: model's prev=1 expects no edge until a low phase.
    idle(12);

    // Single event mid-period, 4:1 ratio.
    to_rise();
    idle(1);
    cycle(1'b1, 32'hA5);
    idle(12);
    check("a5_high_cycles", DW'(a5_cycles), DW'(4));

    // Four back-to-back pushes starting on a slow edge fill the buffer.
    to_rise();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i));
    check("full_after_4", DW'(full), DW'(1));
    idle(20);

    // Full buffer with a slow period of 8: fifth push lands mid-period and is dropped.
    hl = 4;
    to_rise();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i));
    cycle(1'b1, 32'h5);
    idle(40);
    check("dropped_never_seen", DW'(seen5), DW'(0));

    // Full buffer, fifth push exactly on a slow edge is accepted.
    hl = 2;
    to_rise();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i));
    to_rise();
    cycle(1'b1, 32'h55);
    idle(30);

    // Push on the slow-edge cycle with an empty buffer: delivered one period later.
    to_rise();
    cycle(1'b1, 32'h77);
    idle(10);

    // Mid-operation reset with pending events and signal_out high.
    to_rise();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(32'h10 + i));
    to_rise();
    cycle(1'b0, '0);
    check("pre_reset_sig", DW'(signal_out), DW'(1));
    reset = 1'b0;
    #1;
    check("async_sig",  DW'(signal_out), '0);
    check("async_data", data_out, '0);
    check("async_full", DW'(full), '0);
    model_reset();
    @(posedge clk_fast);
    #1;
    reset_cycles(2);
    reset = 1'b1;
    idle(30);

    // Randomized traffic with varying slow-phase lengths.
    rand_hl = 1'b1;
    for (int i = 0; i < 3000; i++) cycle(1'(($urandom % 5) < 2), $urandom);
    rand_hl = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
